// File: rtl/handshake_responder.sv
// Receiving end of the toggle-handshake bus: buffers port1 requests in a show-ahead FIFO
// and returns ack toggle + free-slot count on port2. Optional parity: HANDSHAKE_RESPONDER_PARITY_EN.
module handshake_responder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] port1_i,
    output logic [WIDTH-1:0] port2_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-2:0] out_data,
    output logic             err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-2:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    free_reg;
    logic             last_tog_reg;
    logic             ack_tog_reg;
    logic             err_reg;

    logic             pending;
    logic             accept;
    logic             push;
    logic             pop;
    logic             par_ok;
    logic [WIDTH-2:0] wr_data;

`ifdef HANDSHAKE_RESPONDER_PARITY_EN
    // Even parity over the parity bit plus the narrowed payload.
    assign par_ok  = ~^port1_i[WIDTH-2:0];
    assign wr_data = {1'b0, port1_i[WIDTH-3:0]};
    assign err_o   = err_reg;
`else
    assign par_ok  = 1'b1;
    assign wr_data = port1_i[WIDTH-2:0];
    assign err_o   = 1'b0;
`endif

    // A full FIFO withholds the ack; a same-cycle pop does not make room.
    assign pending = port1_i[WIDTH-1] != last_tog_reg;
    assign accept  = pending && (count_reg != FULL);
    assign push    = accept && par_ok;
    assign pop     = (count_reg != '0) && out_ready;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_tog_reg <= 1'b0;
            ack_tog_reg  <= 1'b0;
            err_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            free_reg     <= FULL;
        end else begin
            if (accept) begin
                last_tog_reg <= port1_i[WIDTH-1];
                ack_tog_reg  <= port1_i[WIDTH-1];
                if (!par_ok) begin
                    err_reg <= 1'b1;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            free_reg  <= FULL - count_next;
        end
    end

    // Storage carries no reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    assign out_valid = (count_reg != '0);
    assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : '0;
    assign port2_o   = {ack_tog_reg, (WIDTH-1)'(free_reg)};

endmodule

// File: tb/tb_handshake_responder.sv
// Self-checking bench for handshake_responder: directed scenarios plus a randomized
// initiator/consumer run checked against a queue-based reference model.
module tb_handshake_responder;
    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] port1_i = '0;
    logic [W-1:0] port2_o;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-2:0] out_data;
    logic         err_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [W-2:0] m_q[$];
    logic         m_last = 1'b0;
    logic         m_ack = 1'b0;
    logic         m_err = 1'b0;
    logic         tog = 1'b0;

    handshake_responder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .port1_i(port1_i),
        .port2_o(port2_o),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Build a request word whose payload is legal for the current build.
    function automatic logic [W-1:0] mk_req(input logic t, input logic [W-2:0] p);
        logic [W-2:0] q;
        q = p;
`ifdef HANDSHAKE_RESPONDER_PARITY_EN
        q[W-2] = ^p[W-3:0];
`endif
        return {t, q};
    endfunction

    // Advance the model by one edge using the current inputs, then move past the edge.
    task automatic cycle();
        logic         pend, acc, pop_e, ok;
        logic [W-2:0] pl;
        if (rst) begin
            m_q.delete();
            m_last = 1'b0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
        end else begin
            pend  = port1_i[W-1] != m_last;
            acc   = pend && (m_q.size() < D);
            pop_e = (m_q.size() > 0) && out_ready;
            ok    = 1'b1;
            pl    = port1_i[W-2:0];
`ifdef HANDSHAKE_RESPONDER_PARITY_EN
            ok = (^port1_i[W-2:0]) == 1'b0;
            pl = {1'b0, port1_i[W-3:0]};
`endif
            if (pop_e) void'(m_q.pop_front());
            if (acc) begin
                m_last = port1_i[W-1];
                m_ack  = port1_i[W-1];
                if (ok) m_q.push_back(pl);
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; port1_i = '0; out_ready = 1'b0; tog = 1'b0;
        repeat (3) cycle();
        tests_run++;
        if (out_valid !== 1'b0 || port2_o !== 32'h0000_0004 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: valid=%b port2=%h err=%b required valid=0 port2=00000004 err=0", out_valid, port2_o, err_o);
        end
        rst = 1'b0;
        repeat (2) cycle();
        tests_run++;
        if (out_valid !== 1'b0 || port2_o !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL reset_release: valid=%b port2=%h required valid=0 port2=00000004", out_valid, port2_o);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        tog = 1'b1;
        port1_i = mk_req(tog, 31'h0AB);
        cycle();
        tests_run++;
        if (port2_o !== 32'h8000_0003 || out_valid !== 1'b1 || out_data !== 31'h0AB) begin
            tests_failed++;
            $display("FAIL single_accept: port2=%h valid=%b data=%h required port2=80000003 valid=1 data=000000ab", port2_o, out_valid, out_data);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || port2_o[W-2:0] !== 31'd4) begin
            tests_failed++;
            $display("FAIL single_pop: valid=%b free=%0d required valid=0 free=4", out_valid, port2_o[W-2:0]);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_full();
        logic prev;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tog = ~tog;
            port1_i = mk_req(tog, 31'(i));
            cycle();
            cycle();
        end
        tests_run++;
        if (port2_o[W-2:0] !== 31'd0 || port2_o[W-1] !== tog) begin
            tests_failed++;
            $display("FAIL full_fill: port2=%h required free=0 ack=%b", port2_o, tog);
        end
        prev = tog;
        tog = ~tog;
        port1_i = mk_req(tog, 31'd5);
        repeat (3) cycle();
        tests_run++;
        if (port2_o[W-1] !== prev || port2_o[W-2:0] !== 31'd0) begin
            tests_failed++;
            $display("FAIL full_withhold: port2=%h required ack=%b free=0", port2_o, prev);
        end
        tests_run++;
        if (out_data !== 31'd1) begin
            tests_failed++;
            $display("FAIL full_head: data=%h required 1", out_data);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        tests_run++;
        if (port2_o[W-1] !== prev || port2_o[W-2:0] !== 31'd1) begin
            tests_failed++;
            $display("FAIL full_pop_no_push: port2=%h required ack=%b free=1", port2_o, prev);
        end
        cycle();
        tests_run++;
        if (port2_o[W-1] !== tog || port2_o[W-2:0] !== 31'd0) begin
            tests_failed++;
            $display("FAIL full_late_push: port2=%h required ack=%b free=0", port2_o, tog);
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 31'(k)) begin
                tests_failed++;
                $display("FAIL full_order: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, 31'(k));
            end
            cycle();
        end
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || port2_o[W-2:0] !== 31'd4) begin
            tests_failed++;
            $display("FAIL full_drained: valid=%b free=%0d required valid=0 free=4", out_valid, port2_o[W-2:0]);
        end
        $display("[TB] test_full done");
    endtask

    task automatic test_push_pop();
        logic [W-2:0] exp_head;
        out_ready = 1'b0;
        repeat (2) begin
            tog = ~tog;
            port1_i = mk_req(tog, 31'($urandom));
            cycle();
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_head = (m_q.size() > 0) ? m_q[0] : '0;
            tests_run++;
            if (out_data !== exp_head) begin
                tests_failed++;
                $display("FAIL pushpop_head[%0d]: data=%h required %h", i, out_data, exp_head);
            end
            tog = ~tog;
            port1_i = mk_req(tog, 31'($urandom));
            cycle();
            tests_run++;
            if (port2_o[W-2:0] !== 31'd2 || port2_o[W-1] !== tog) begin
                tests_failed++;
                $display("FAIL pushpop_count[%0d]: port2=%h required ack=%b free=2", i, port2_o, tog);
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_head = m_q[0];
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_head) begin
                tests_failed++;
                $display("FAIL pushpop_drain[%0d]: valid=%b data=%h required valid=1 data=%h", i, out_valid, out_data, exp_head);
            end
            cycle();
        end
        out_ready = 1'b0;
        $display("[TB] test_push_pop done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        repeat (3) begin
            tog = ~tog;
            port1_i = mk_req(tog, 31'($urandom));
            cycle();
            cycle();
        end
        tests_run++;
        if (port2_o[W-2:0] !== 31'd1) begin
            tests_failed++;
            $display("FAIL midrst_fill: free=%0d required 1", port2_o[W-2:0]);
        end
        rst = 1'b1; port1_i = '0; tog = 1'b0;
        cycle();
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || port2_o !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL midrst_clear: valid=%b port2=%h required valid=0 port2=00000004", out_valid, port2_o);
        end
        tog = 1'b1;
        port1_i = mk_req(tog, 31'h55);
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests_run++;
            if (port2_o !== 32'h8000_0003 || out_data !== 31'h55) begin
                tests_failed++;
                $display("FAIL midrst_once[%0d]: port2=%h data=%h required port2=80000003 data=00000055", i, port2_o, out_data);
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        logic [W+W+1:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 59) == 0);
            if (rst) begin
                port1_i = '0;
                tog = 1'b0;
            end else if (m_ack == tog && $urandom_range(0, 1) == 1) begin
                tog = ~tog;
                port1_i = {tog, 31'($urandom)};
            end
            cycle();
            exp = {(m_q.size() != 0), ((m_q.size() != 0) ? m_q[0] : 31'd0),
                   m_ack, 31'(D - m_q.size()),
`ifdef HANDSHAKE_RESPONDER_PARITY_EN
                   m_err};
`else
                   1'b0};
`endif
            got = {out_valid, out_data, port2_o, err_o};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d]: valid/data/port2/err=%h required %h", i, got, exp);
            end
        end
        rst = 1'b0; out_ready = 1'b0;
        $display("[TB] test_random done");
    endtask

`ifdef HANDSHAKE_RESPONDER_PARITY_EN
    task automatic test_parity();
        rst = 1'b1; port1_i = '0; tog = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b0;
        tog = 1'b1;
        port1_i = {1'b1, 1'b0, 30'h1};
        cycle();
        tests_run++;
        if (port2_o !== 32'h8000_0004 || out_valid !== 1'b0 || err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_bad: port2=%h valid=%b err=%b required port2=80000004 valid=0 err=1", port2_o, out_valid, err_o);
        end
        tog = 1'b0;
        port1_i = {1'b0, 1'b1, 30'h1};
        cycle();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 31'h1 || err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_good: valid=%b data=%h err=%b required valid=1 data=00000001 err=1", out_valid, out_data, err_o);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests_run++;
        if (err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_clear: err=%b required 0", err_o);
        end
        $display("[TB] test_parity done");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_push_pop();
        test_reset_mid();
        test_random();
`ifdef HANDSHAKE_RESPONDER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/handshake_responder.md
Name: handshake_responder

Overview:
- Receiving (dir2-side) end of the two-bus handshake interface; the counterpart of the initiator that drives port1.
- Detects toggle-encoded requests on port1 and buffers their payloads in a DEPTH-entry FIFO.
- Presents buffered payloads to local logic over a valid/ready stream.
- Returns a toggle acknowledge plus a free-slot count on port2.

Parameters:
- WIDTH, 32, width of port1/port2; bit WIDTH-1 is the toggle bit.
- DEPTH, 4, FIFO entries; power of 2, >=2; $clog2(DEPTH)+1 <= WIDTH-1.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- port1_i  input  WIDTH  request bus: [WIDTH-1] req toggle, [WIDTH-2:0] payload
- port2_o  output  WIDTH  response bus: [WIDTH-1] ack toggle, [WIDTH-2:0] zero-extended free-slot count
- out_valid  output  1  FIFO head valid
- out_ready  input  1  local consumer ready
- out_data  output  WIDTH-1  FIFO head payload
- err_o  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset: one clock; rst synchronous, active-high, sampled on clk rising edge. While rst is high:
  - last_tog_q=0, ack_tog_q=0, count=0, rd/wr pointers=0, err_o=0.
  - Outputs: out_valid=0, out_data=0, port2_o={1'b0, DEPTH}.
- Reset mid-transfer discards all FIFO contents and any pending request. The initiator must also be reset.
- Pending request: port1_i[WIDTH-1] != last_tog_q. Initiator holds port1_i stable until port2_o[WIDTH-1] equals its toggle.
- Accept: pending && count<DEPTH. On that edge:
  - write payload at wr_ptr; wr_ptr++;
  - last_tog_q <= port1_i[WIDTH-1]; ack_tog_q <= port1_i[WIDTH-1].
- Full (count==DEPTH): a pending request is not accepted and the ack is withheld.
  - A pop in the same cycle does not free a slot for that cycle's push.
  - The push occurs on the next edge, if the request is still pending.
- Pop: out_valid && out_ready; rd_ptr++.
- Count: push-only +1, pop-only -1, push+pop same edge unchanged (only possible when count<DEPTH and count>0).
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- FIFO is show-ahead: out_valid=(count!=0), out_data=mem[rd_ptr]; when count==0, out_data=0.
- Latency:
  - request first visible in cycle N with count<DEPTH -> ack toggles on port2_o and out_valid rises in cycle N+1 (if FIFO was empty);
  - minimum sustained rate: one request per 2 cycles (initiator turnaround).
- port2_o[WIDTH-2:0] = DEPTH-count, registered, updated on the same edge as count.
- No pending request and no pop: all state holds.
- At most one accept per toggle transition. A toggle that does not change generates nothing.

Optional Feature:
- Macro: HANDSHAKE_RESPONDER_PARITY_EN.
- Defined:
  - port1_i[WIDTH-2] is an even-parity bit over port1_i[WIDTH-3:0].
  - Payload is [WIDTH-3:0], zero-extended into out_data (out_data[WIDTH-2]=0).
  - On a parity failure the request is still acknowledged (toggle updated) but not written to the FIFO, and err_o is set.
  - err_o stays high until rst. Parity is checked only at accept.
- Not defined: full WIDTH-1-bit payload, no check, err_o tied 0.

Test Plan:
- Reset: hold rst 3 cycles with port1_i=0 -> out_valid=0, port2_o=32'h0000_0004, err_o=0; release -> no spurious accept.
- Single request: port1_i=32'h8000_00AB in cycle N -> N+1: port2_o=32'h8000_0003, out_valid=1, out_data=31'h0AB; out_ready=1 -> N+2: out_valid=0, port2_o[30:0]=4.
- Full/backpressure: out_ready=0, send 4 requests (toggle 1,0,1,0; payloads 1..4) -> port2_o[30:0]=0. Fifth request (toggle 1, payload 5) -> ack not toggled while out_ready=0. Raise out_ready for one cycle -> payload 5 accepted on the following edge; pops return 1,2,3,4,5 in order.
- Simultaneous push/pop: count=2, new request with out_ready=1 -> count stays 2, port2_o[30:0]=2, order preserved. Repeat 9 times to cover pointer wrap.
- Reset mid-operation: FIFO holding 3 entries, assert rst 1 cycle -> out_valid=0, free=4; a request with toggle 1 presented afterwards is accepted exactly once.
- Parity (macro defined): payload 30'h1 with bit30=0 -> ack toggles, out_valid stays 0, err_o=1 until rst; same payload with bit30=1 -> accepted, out_data=31'h1.
